// File: rtl/upsample2.sv
// 2x nearest-neighbour upsampler: each pixel is emitted twice, and each row is
// emitted twice, the second time replayed from an internal row buffer.
module upsample2 #(
    parameter int unsigned DW    = 8,
    parameter int unsigned ROW_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] m_data,
    input  logic          m_valid,
    output logic          m_ready,
    output logic [DW-1:0] s_data,
    output logic          s_valid,
    input  logic          s_ready
);

    localparam int unsigned AW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam logic [AW-1:0] LAST = AW'(ROW_W - 1);

    typedef enum logic {
        ROW0 = 1'b0,
        ROW1 = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] h;
    logic          hv;
    logic          phase;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] col;
    logic [DW-1:0] row_buf [ROW_W];

    logic in_hs;
    logic out_hs;
    logic retire;
    logic last_col;

    assign in_hs    = m_valid & m_ready;
    assign out_hs   = s_valid & s_ready;
    assign retire   = out_hs & phase;
    assign last_col = (col == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ROW0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a row phase ends when the last column's second copy retires
    always_comb begin
        state_nxt = state;
        if (retire && last_col) begin
            state_nxt = (state == ROW0) ? ROW1 : ROW0;
        end
    end

    // Outputs: ROW0 shows the hold register, ROW1 reads the row buffer directly
    always_comb begin
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = h;
        case (state)
            ROW0: begin
                s_valid = hv;
                s_data  = h;
                m_ready = !hv | (s_ready & phase & !last_col);
            end
            ROW1: begin
                s_valid = 1'b1;
                s_data  = row_buf[col];
            end
            default: begin
                s_valid = 1'b0;
            end
        endcase
    end

    // Hold register, copy phase and row pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h      <= '0;
            hv     <= 1'b0;
            phase  <= 1'b0;
            wr_ptr <= '0;
            col    <= '0;
        end else begin
            if (out_hs) begin
                phase <= ~phase;
            end
            if (state == ROW0) begin
                if (in_hs) begin
                    h      <= m_data;
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
                end
                if (in_hs) begin
                    hv <= 1'b1;
                end else if (retire) begin
                    hv <= 1'b0;
                end
                if (retire) begin
                    if (last_col) begin
                        col    <= '0;
                        wr_ptr <= '0;
                    end else begin
                        col <= col + AW'(1);
                    end
                end
            end else begin
                hv <= 1'b0;
                if (retire) begin
                    col <= last_col ? '0 : col + AW'(1);
                end
            end
        end
    end

    // Row buffer captures every pixel accepted during ROW0; contents need no reset
    always_ff @(posedge clk) begin
        if (in_hs) begin
            row_buf[wr_ptr] <= m_data;
        end
    end

endmodule

// File: tb/tb_upsample2.sv
// Bench for upsample2: a ROW_W=4 and a ROW_W=3 instance, each checked against a
// queue-based model of the doubled pixel / doubled row output stream.
module tb_upsample2;

    logic       clk;
    logic       rst_n;
    logic [7:0] m_data_a, s_data_a, m_data_b, s_data_b;
    logic       m_valid_a, m_ready_a, s_valid_a, s_ready_a;
    logic       m_valid_b, m_ready_b, s_valid_b, s_ready_b;

    int checks = 0;
    int errors = 0;

    upsample2 #(.DW(8), .ROW_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a)
    );

    upsample2 #(.DW(8), .ROW_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source side: pixels waiting to be sent, plus idle cycles between pixels
    logic [7:0] src_a[$];
    logic [7:0] src_b[$];
    int         gap_a = 1, gap_b = 1, hold_a = 0, hold_b = 0;
    bit         acc_a = 0, acc_b = 0;
    int         sr_mode = 0;   // 0: always ready, 1: toggling, 2: random
    bit         sr_t = 0;

    // Reference model: expected output pixels and the row being collected
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] row_a[$];
    logic [7:0] row_b[$];
    bit         stall_a = 0, stall_b = 0;
    logic [7:0] held_a, held_b;

    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (!rst_n) begin
            exp_a.delete(); row_a.delete(); exp_b.delete(); row_b.delete();
            stall_a = 0; stall_b = 0;
        end else begin
            if (stall_a) begin
                checks++;
                if (s_valid_a !== 1'b1 || s_data_a !== held_a) begin
                    errors++;
                    $display("FAIL hold_a: s_valid=%0b s_data=%02h, required 1 %02h", s_valid_a, s_data_a, held_a);
                end
            end
            if (s_valid_a === 1'b1 && s_ready_a === 1'b1) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL data_a: unexpected output %02h, required none", s_data_a);
                end else begin
                    e = exp_a.pop_front();
                    if (s_data_a !== e) begin
                        errors++;
                        $display("FAIL data_a: s_data=%02h, required %02h", s_data_a, e);
                    end
                end
            end
            if (m_valid_a === 1'b1 && m_ready_a === 1'b1) begin
                exp_a.push_back(m_data_a); exp_a.push_back(m_data_a);
                row_a.push_back(m_data_a);
                if (row_a.size() == 4) begin
                    foreach (row_a[i]) begin exp_a.push_back(row_a[i]); exp_a.push_back(row_a[i]); end
                    row_a.delete();
                end
            end
            stall_a = (s_valid_a === 1'b1) && (s_ready_a !== 1'b1);
            held_a  = s_data_a;

            if (stall_b) begin
                checks++;
                if (s_valid_b !== 1'b1 || s_data_b !== held_b) begin
                    errors++;
                    $display("FAIL hold_b: s_valid=%0b s_data=%02h, required 1 %02h", s_valid_b, s_data_b, held_b);
                end
            end
            if (s_valid_b === 1'b1 && s_ready_b === 1'b1) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL data_b: unexpected output %02h, required none", s_data_b);
                end else begin
                    e = exp_b.pop_front();
                    if (s_data_b !== e) begin
                        errors++;
                        $display("FAIL data_b: s_data=%02h, required %02h", s_data_b, e);
                    end
                end
            end
            if (m_valid_b === 1'b1 && m_ready_b === 1'b1) begin
                exp_b.push_back(m_data_b); exp_b.push_back(m_data_b);
                row_b.push_back(m_data_b);
                if (row_b.size() == 3) begin
                    foreach (row_b[i]) begin exp_b.push_back(row_b[i]); exp_b.push_back(row_b[i]); end
                    row_b.delete();
                end
            end
            stall_b = (s_valid_b === 1'b1) && (s_ready_b !== 1'b1);
            held_b  = s_data_b;
        end
    end

    // One clock of stimulus; returns 2 time units after the falling edge
    task automatic tick();
        bit rdy;
        if (acc_a) begin void'(src_a.pop_front()); hold_a = gap_a - 1; end
        else if (hold_a > 0) hold_a--;
        if (acc_b) begin void'(src_b.pop_front()); hold_b = gap_b - 1; end
        else if (hold_b > 0) hold_b--;
        @(negedge clk);
        sr_t = ~sr_t;
        rdy = (sr_mode == 0) ? 1'b1 : (sr_mode == 1) ? sr_t : ($urandom_range(3) != 0);
        s_ready_a = rdy;
        s_ready_b = (sr_mode == 2) ? ($urandom_range(3) != 0) : rdy;
        m_valid_a = (src_a.size() > 0) && (hold_a == 0);
        m_data_a  = m_valid_a ? src_a[0] : 8'($urandom);
        m_valid_b = (src_b.size() > 0) && (hold_b == 0);
        m_data_b  = m_valid_b ? src_b[0] : 8'($urandom);
        #2;
        acc_a = m_valid_a & m_ready_a;
        acc_b = m_valid_b & m_ready_b;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (src_a.size() == 0 && src_b.size() == 0 && exp_a.size() == 0 &&
                exp_b.size() == 0 && !acc_a && !acc_b) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_valid_a = 0; m_valid_b = 0; m_data_a = 0; m_data_b = 0;
        s_ready_a = 1; s_ready_b = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (s_valid_a !== 1'b0 || s_data_a !== 8'h00 || m_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_a: v=%0b d=%02h r=%0b, required 0 00 1", s_valid_a, s_data_a, m_ready_a);
        end
        checks++;
        if (s_valid_b !== 1'b0 || s_data_b !== 8'h00 || m_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_b: v=%0b d=%02h r=%0b, required 0 00 1", s_valid_b, s_data_b, m_ready_b);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        bit ok;
        sr_mode = 0;
        src_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int c = 0; c < 18; c++) begin
            bit er, ev;
            tick();
            er = (c < 8) ? (c % 2 == 0) : (c == 17);
            ev = (c >= 1) && (c <= 16);
            checks++;
            if (m_ready_a !== er) begin
                errors++;
                $display("FAIL pass_m_ready c=%0d: got %0b, required %0b", c, m_ready_a, er);
            end
            checks++;
            if (s_valid_a !== ev) begin
                errors++;
                $display("FAIL pass_s_valid c=%0d: got %0b, required %0b", c, s_valid_a, ev);
            end
        end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pass_drain: got not idle, required idle"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        sr_mode = 1;
        src_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain: got not idle, required idle"); end
        sr_mode = 0;
    endtask

    task automatic test_input_gaps();
        bit ok;
        int outs = 0, drops = 0;
        gap_a = 3;
        src_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int c = 0; c < 80 && outs < 16; c++) begin
            tick();
            if (outs >= 1 && outs < 8 && s_valid_a === 1'b0) drops++;
            if (outs >= 8) begin
                checks++;
                if (s_valid_a !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_replay out=%0d: s_valid=%0b, required 1", outs, s_valid_a);
                end
            end
            if (s_valid_a === 1'b1 && s_ready_a === 1'b1) outs++;
        end
        checks++;
        if (drops == 0) begin errors++; $display("FAIL gap_drops: got %0d idle cycles, required >0", drops); end
        checks++;
        if (outs != 16) begin errors++; $display("FAIL gap_count: got %0d outputs, required 16", outs); end
        gap_a = 1;
        wait_idle(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gap_drain: got not idle, required idle"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int outs = 0, last_c = -1, acc_c = -1;
        src_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        for (int c = 0; c < 60 && acc_c < 0; c++) begin
            tick();
            if (acc_a && m_data_a == 8'd5) acc_c = c;
            if (s_valid_a === 1'b1 && s_ready_a === 1'b1) begin
                outs++;
                if (outs == 16) last_c = c;
            end
        end
        checks++;
        if (acc_c != last_c + 1 || last_c < 0) begin
            errors++;
            $display("FAIL b2b_timing: row2 accepted at %0d, required %0d", acc_c, last_c + 1);
        end
        wait_idle(80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got not idle, required idle"); end
    endtask

    task automatic test_reset_mid_replay();
        bit ok;
        int outs = 0;
        src_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int c = 0; c < 40 && outs < 11; c++) begin
            tick();
            if (s_valid_a === 1'b1 && s_ready_a === 1'b1) outs++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (s_valid_a !== 1'b0) begin errors++; $display("FAIL rst_async: s_valid=%0b, required 0", s_valid_a); end
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (m_ready_a !== 1'b1) begin errors++; $display("FAIL rst_ready: m_ready=%0b, required 1", m_ready_a); end
        src_a = '{8'd9, 8'd10, 8'd11, 8'd12};
        wait_idle(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_drain: got not idle, required idle"); end
    endtask

    task automatic test_boundary_row3();
        bit ok, seen = 0, done = 0;
        int run = 0;
        src_b = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (s_valid_b === 1'b1) begin seen = 1; run++; end
            else if (seen) done = 1;
        end
        checks++;
        if (run != 12) begin errors++; $display("FAIL row3_run: got %0d outputs, required 12", run); end
        wait_idle(80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL row3_drain: got not idle, required idle"); end
    endtask

    task automatic test_random();
        bit ok;
        sr_mode = 2;
        gap_a = $urandom_range(3, 1);
        gap_b = $urandom_range(3, 1);
        for (int i = 0; i < 16; i++) src_a.push_back(8'($urandom));
        for (int i = 0; i < 15; i++) src_b.push_back(8'($urandom));
        wait_idle(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_drain: got not idle, required idle"); end
        sr_mode = 0; gap_a = 1; gap_b = 1;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_input_gaps();
        test_back_to_back();
        test_reset_mid_replay();
        test_boundary_row3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
